// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and the round-robin search helper for the sync_fifo write-port arbiter.
// The helper works on a fixed 16-wide vector so that any NUM_REQ up to 16 can reuse it.
package sync_fifo_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan start, start+1, ... num-1, 0, ... start-1 and return the first valid index.
  // Only one subtraction is needed to wrap, because start < num and k < num.
  function automatic rr_pick_t rr_next_owner(input logic [MAX_REQ-1:0] valid,
                                             input logic [IDX_W-1:0]   start,
                                             input int                 num);
    rr_pick_t pick;
    int       j;
    pick = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(start) + k;
      if (j >= num) j = j - num;
      if (k < num && !pick.found && valid[j[IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = j[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sync_fifo_rr_pick.sv
// Combinational round-robin picker: widens the request vector and applies rr_next_owner.
// A single instance serves both the idle-grant search and the release-time search.
module sync_fifo_rr_pick
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [OWN_W-1:0]   start,
  output logic               found,
  output logic [OWN_W-1:0]   idx
);

  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    pick                     = rr_next_owner(valid_ext, IDX_W'(start), NUM_REQ);
  end

  assign found = pick.found;
  assign idx   = pick.idx[OWN_W-1:0];

  // The picked index is always below NUM_REQ, so the upper bits are structurally zero.
  generate
    if (OWN_W < IDX_W) begin : g_spare
      logic unused_idx_bits;
      assign unused_idx_bits = ^pick.idx[IDX_W-1:OWN_W];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo push port among NUM_REQ valid/ready/last producers.
// A grant stays with one owner for up to MAX_BURST beats and never pushes into a full FIFO.
module sync_fifo_wr_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  WIDTH     = 32,
  parameter int  MAX_BURST = 4,
  localparam int OWN_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     fifo_full,
  output logic                     busy,
  output logic [OWN_W-1:0]         owner
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state;
  logic [OWN_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic             in_burst;
  logic             owner_valid;
  logic             owner_last;
  logic             accept;
  logic             last_beat;
  logic             release_now;
  logic [OWN_W-1:0] next_start;
  logic [OWN_W-1:0] search_start;
  logic             pick_found;
  logic [OWN_W-1:0] pick_idx;

  assign in_burst     = (state == ARB_BURST);
  assign busy         = in_burst;
  assign owner_valid  = req_valid[owner];
  assign owner_last   = req_last[owner];
  assign accept       = in_burst && owner_valid && !fifo_full;
  assign fifo_push    = accept;
  assign last_beat    = owner_last || (beat_cnt == CNT_W'(MAX_BURST - 1));
  // An idle owner gives up the grant even while the FIFO is full, so a stalled burst cannot lock out others.
  assign release_now  = in_burst && (!owner_valid || (accept && last_beat));
  assign next_start   = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + OWN_W'(1);
  assign search_start = in_burst ? next_start : rr_ptr;

  sync_fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_pick (
    .valid (req_valid),
    .start (search_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    if (in_burst) begin
      req_ready[owner] = !fifo_full;
      fifo_data_in     = req_data[int'(owner)*WIDTH +: WIDTH];
    end
  end

  // On release the next owner is chosen in the same cycle, so back-to-back bursts have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (enable && pick_found) begin
            state    <= ARB_BURST;
            owner    <= pick_idx;
            beat_cnt <= '0;
          end
        end
        ARB_BURST: begin
          if (release_now) begin
            rr_ptr   <= next_start;
            beat_cnt <= '0;
            if (enable && pick_found) owner <= pick_idx;
            else                      state <= ARB_IDLE;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Testbench for sync_fifo_wr_arbiter: a vector table, directed corner sequences and
// randomized traffic compared against a behavioural model of the arbitration rules.
module tb_sync_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     enable = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_last = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_push;
  logic [WIDTH-1:0]         fifo_data_in;
  logic                     fifo_full = 1'b0;
  logic                     busy;
  logic [1:0]               owner;

  logic [WIDTH-1:0] data_q [NUM_REQ];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: plain integers describing who holds the grant and for how long.
  bit m_busy;
  int m_owner;
  int m_rr;
  int m_beats;

  // Outputs sampled mid-cycle by applyStimulus.
  logic             s_push;
  logic             s_busy;
  logic [1:0]       s_owner;
  logic [3:0]       s_ready;
  logic [WIDTH-1:0] s_data;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic       en;
    logic       exp_push;
    logic       exp_busy;
    logic [1:0] exp_owner;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t tbl [17];

  sync_fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_push    (fifo_push),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .busy         (busy),
    .owner        (owner)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = data_q[i];
  end

  function automatic int rr_search(logic [3:0] v, int start);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (start + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_rr    = 0;
    m_beats = 0;
  endtask

  task automatic check_model(input string tag);
    logic       exp_push;
    logic [3:0] exp_ready;
    logic [31:0] exp_data;
    exp_push  = m_busy && req_valid[m_owner] && !fifo_full;
    exp_ready = (m_busy && !fifo_full) ? (4'b0001 << m_owner) : 4'b0000;
    exp_data  = m_busy ? data_q[m_owner] : 32'h0;
    checkOutput({tag, ".push"},  32'(fifo_push), 32'(exp_push));
    checkOutput({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
    checkOutput({tag, ".data"},  fifo_data_in,   exp_data);
    checkOutput({tag, ".busy"},  32'(busy),      32'(m_busy));
    if (m_busy) checkOutput({tag, ".owner"}, 32'(owner), 32'(m_owner));
  endtask

  // Advance the model by one clock edge using the inputs present before that edge.
  task automatic model_advance();
    bit pushed;
    bit done;
    int nxt;
    if (!m_busy) begin
      if (enable && req_valid != 4'b0000) begin
        m_busy  = 1'b1;
        m_owner = rr_search(req_valid, m_rr);
        m_beats = 0;
      end
    end else begin
      pushed = req_valid[m_owner] && !fifo_full;
      done   = !req_valid[m_owner] || (pushed && (req_last[m_owner] || m_beats + 1 == MAX_BURST));
      if (done) begin
        m_rr    = (m_owner + 1) % NUM_REQ;
        nxt     = rr_search(req_valid, m_rr);
        m_beats = 0;
        if (enable && nxt >= 0) m_owner = nxt;
        else                    m_busy  = 1'b0;
      end else if (pushed) begin
        m_beats++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic f,
                               input logic en, input string tag);
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    enable    = en;
    #1;
    s_push  = fifo_push;
    s_busy  = busy;
    s_owner = owner;
    s_ready = req_ready;
    s_data  = fifo_data_in;
    check_model(tag);
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    enable    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int         push_idx;
    int         seq [NUM_REQ];
    logic [31:0] exp_d;

    for (int i = 0; i < NUM_REQ; i++) data_q[i] = 32'hD000_0000 + i;
    model_reset();

    // Reset state
    #2;
    checkOutput("reset.busy",  32'(busy),      32'h0);
    checkOutput("reset.push",  32'(fifo_push), 32'h0);
    checkOutput("reset.ready", 32'(req_ready), 32'h0);
    checkOutput("reset.data",  fifo_data_in,   32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Early last hand-off (req1 -> req3), full stall on req2, wrap-around of the search pointer.
    tbl[0]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[1]  = '{4'b1010, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
    tbl[2]  = '{4'b1010, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
    tbl[3]  = '{4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000};
    tbl[5]  = '{4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[7]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[8]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[9]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[10] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[11] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[12] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[14] = '{4'b1001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[15] = '{4'b1001, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
    tbl[16] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].valid, tbl[i].last, tbl[i].full, tbl[i].en, $sformatf("tbl%0d", i));
      exp_d = tbl[i].exp_busy ? 32'hD000_0000 + 32'(tbl[i].exp_owner) : 32'h0;
      checkOutput($sformatf("tbl%0d.push", i),  32'(s_push),  32'(tbl[i].exp_push));
      checkOutput($sformatf("tbl%0d.busy", i),  32'(s_busy),  32'(tbl[i].exp_busy));
      checkOutput($sformatf("tbl%0d.ready", i), 32'(s_ready), 32'(tbl[i].exp_ready));
      checkOutput($sformatf("tbl%0d.data", i),  s_data,       exp_d);
      if (tbl[i].exp_busy)
        checkOutput($sformatf("tbl%0d.owner", i), 32'(s_owner), 32'(tbl[i].exp_owner));
    end

    // Single requester streaming 6 beats across a MAX_BURST boundary.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      data_q[0] = 32'h1000 + k;
      applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b1, "t1");
      checkOutput($sformatf("t1.push%0d", k), 32'(s_push), 32'(k >= 1));
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, "t1.drop");
    applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b1, "t1.regrant");
    applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b1, "t1.rr");
    checkOutput("t1.rr_owner", 32'(s_owner), 32'd1);

    // All requesters valid: round-robin order 0,1,2,3 with 4 beats each, then back to 0.
    do_reset();
    push_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
    for (int c = 0; c < 18; c++) begin
      for (int i = 0; i < NUM_REQ; i++) data_q[i] = {8'(i), 24'(seq[i])};
      applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b1, "t2");
      if (s_push) begin
        checkOutput($sformatf("t2.order%0d", push_idx), 32'(s_owner), 32'((push_idx / 4) % 4));
        seq[s_owner]++;
        push_idx++;
      end
    end
    checkOutput("t2.push_count", 32'(push_idx), 32'd17);

    // enable drops mid-burst: burst completes, then no new grant until enable returns.
    do_reset();
    applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b1, "t5.grant");
    for (int k = 0; k < 4; k++) applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, "t5.burst");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, "t5.hold");
      checkOutput($sformatf("t5.idle%0d", k), 32'(s_busy), 32'h0);
    end
    applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b1, "t5.regrant");
    applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b1, "t5.owner");
    checkOutput("t5.owner1", 32'(s_owner), 32'd1);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b1, "t6.grant");
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b1, "t6.beat");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6.busy",  32'(busy),      32'h0);
    checkOutput("t6.push",  32'(fifo_push), 32'h0);
    checkOutput("t6.ready", 32'(req_ready), 32'h0);
    checkOutput("t6.data",  fifo_data_in,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b1, "t6.regrant");
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b1, "t6.owner");
    checkOutput("t6.owner3", 32'(s_owner), 32'd3);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) data_q[i] = $urandom;
      applyStimulus(4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) != 0),
                    "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
